// File: rtl/approx_pkg.sv
// Shared types and default widths for the approximate rounding pipeline.
// Mode encoding is fixed by the upstream datapath; 11 is reserved and rounds like truncate.
package approx_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_DROP_W = 8;
  localparam int DEF_LOOK_W = 4;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic [1:0] {
    MODE_TRUNC     = 2'b00,
    MODE_RHU       = 2'b01,
    MODE_RN_APPROX = 2'b10,
    MODE_RSVD      = 2'b11
  } mode_e;

endpackage

// File: rtl/approx_round_dec.sv
// Combinational round-up decision. DROP_W=5 / LOOK_W=4 reproduces the original
// 5-input round-nearest cell (guard OR all four tail bits).
module approx_round_dec
  import approx_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DROP_W = DEF_DROP_W,
  parameter int LOOK_W = DEF_LOOK_W
) (
  input  logic [DATA_W-1:0] data_i,
  input  mode_e             mode_i,
  output logic              up_o
);

  logic guardBit;
  logic tailOnes;
  logic unusedBits;

  assign guardBit = data_i[DROP_W-1];

  // With no look-ahead bits the approximate rule collapses to round-half-up.
  generate
    if (LOOK_W > 0) begin : g_tail
      assign tailOnes = &data_i[DROP_W-2 -: LOOK_W];
    end else begin : g_no_tail
      assign tailOnes = 1'b0;
    end
  endgenerate

  assign unusedBits = ^data_i;

  always_comb begin
    up_o = 1'b0;
    case (mode_i)
      MODE_RHU:       up_o = guardBit;
      MODE_RN_APPROX: up_o = guardBit | tailOnes;
      default:        up_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/approx_round_pipe.sv
// Two-stage valid/ready rounding pipeline with saturation on round-up overflow.
// Define APPROX_ROUND_STATS_EN to build the round-up / saturation counters.
module approx_round_pipe
  import approx_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DROP_W = DEF_DROP_W,
  parameter int LOOK_W = DEF_LOOK_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [1:0]               in_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-DROP_W-1:0] out_data,
  output logic                     out_sat,
  input  logic                     stat_clr,
  output logic [CNT_W-1:0]         stat_rup_cnt,
  output logic [CNT_W-1:0]         stat_sat_cnt
);

  localparam int KEEP_W = DATA_W - DROP_W;

  logic              decUp;
  logic              s1Load;
  logic              s2Load;
  logic              s1Valid_q;
  logic [KEEP_W-1:0] s1Kept_q;
  logic              s1Up_q;
  logic              s2Valid_q;
  logic [KEEP_W-1:0] s2Data_q;
  logic              s2Sat_q;
  logic [KEEP_W:0]   roundSum;
  logic [KEEP_W-1:0] s2Data_d;
  logic              s2Sat_d;

  approx_round_dec #(
    .DATA_W (DATA_W),
    .DROP_W (DROP_W),
    .LOOK_W (LOOK_W)
  ) u_dec (
    .data_i (in_data),
    .mode_i (mode_e'(in_mode)),
    .up_o   (decUp)
  );

  // Ready depends only on stage occupancy and out_ready, never on in_valid.
  assign s2Load   = !s2Valid_q || out_ready;
  assign s1Load   = !s1Valid_q || s2Load;
  assign in_ready = !s1Valid_q || !s2Valid_q || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid_q <= 1'b0;
      s1Kept_q  <= '0;
      s1Up_q    <= 1'b0;
    end else if (s1Load) begin
      s1Valid_q <= in_valid;
      if (in_valid) begin
        s1Kept_q <= in_data[DATA_W-1:DROP_W];
        s1Up_q   <= decUp;
      end
    end
  end

  always_comb begin
    roundSum = {1'b0, s1Kept_q} + {{KEEP_W{1'b0}}, s1Up_q};
    s2Sat_d  = roundSum[KEEP_W];
    s2Data_d = s2Sat_d ? {KEEP_W{1'b1}} : roundSum[KEEP_W-1:0];
  end

  // Data only moves on a real transfer so a stalled result holds its value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2Valid_q <= 1'b0;
      s2Data_q  <= '0;
      s2Sat_q   <= 1'b0;
    end else if (s2Load) begin
      s2Valid_q <= s1Valid_q;
      if (s1Valid_q) begin
        s2Data_q <= s2Data_d;
        s2Sat_q  <= s2Sat_d;
      end
    end
  end

  assign out_valid = s2Valid_q;
  assign out_data  = s2Data_q;
  assign out_sat   = s2Sat_q;

`ifdef APPROX_ROUND_STATS_EN
  logic             outFire;
  logic             s2Up_q;
  logic [CNT_W-1:0] rupCnt_q;
  logic [CNT_W-1:0] rupCnt_d;
  logic [CNT_W-1:0] satCnt_q;
  logic [CNT_W-1:0] satCnt_d;

  assign outFire = s2Valid_q && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2Up_q <= 1'b0;
    end else if (s2Load && s1Valid_q) begin
      s2Up_q <= s1Up_q;
    end
  end

  // Clear wins over a same-cycle increment; counters stick at all ones.
  always_comb begin
    rupCnt_d = rupCnt_q;
    satCnt_d = satCnt_q;
    if (stat_clr) begin
      rupCnt_d = '0;
      satCnt_d = '0;
    end else if (outFire) begin
      if (s2Up_q && (rupCnt_q != {CNT_W{1'b1}})) begin
        rupCnt_d = rupCnt_q + CNT_W'(1);
      end
      if (s2Sat_q && (satCnt_q != {CNT_W{1'b1}})) begin
        satCnt_d = satCnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rupCnt_q <= '0;
      satCnt_q <= '0;
    end else begin
      rupCnt_q <= rupCnt_d;
      satCnt_q <= satCnt_d;
    end
  end

  assign stat_rup_cnt = rupCnt_q;
  assign stat_sat_cnt = satCnt_q;
`else
  logic unusedStatClr;

  assign unusedStatClr = stat_clr;
  assign stat_rup_cnt  = '0;
  assign stat_sat_cnt  = '0;
`endif

endmodule

// File: tb/tb_approx_round_pipe.sv
// Directed self-checking bench for approx_round_pipe (DATA_W=16, DROP_W=8, LOOK_W=4).
// Stat checks follow APPROX_ROUND_STATS_EN; without it the stat outputs must read 0.
module tb_approx_round_pipe;
  import approx_pkg::*;

  localparam int DATA_W = 16;
  localparam int DROP_W = 8;
  localparam int LOOK_W = 4;
  localparam int CNT_W  = 16;
  localparam int KEEP_W = DATA_W - DROP_W;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [1:0]        in_mode;
  logic              out_valid;
  logic              out_ready;
  logic [KEEP_W-1:0] out_data;
  logic              out_sat;
  logic              stat_clr;
  logic [CNT_W-1:0]  stat_rup_cnt;
  logic [CNT_W-1:0]  stat_sat_cnt;

  int testsRun    = 0;
  int testsFailed = 0;

  approx_round_pipe #(
    .DATA_W (DATA_W),
    .DROP_W (DROP_W),
    .LOOK_W (LOOK_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_mode      (in_mode),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_sat      (out_sat),
    .stat_clr     (stat_clr),
    .stat_rup_cnt (stat_rup_cnt),
    .stat_sat_cnt (stat_sat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  mode;
    logic [7:0]  expData;
    logic        expSat;
  } vec_t;

  vec_t vecs [9] = '{
    '{16'h1280, 2'b10, 8'h13, 1'b0},
    '{16'h127F, 2'b10, 8'h13, 1'b0},
    '{16'h127F, 2'b01, 8'h12, 1'b0},
    '{16'h1270, 2'b10, 8'h12, 1'b0},
    '{16'h12FF, 2'b00, 8'h12, 1'b0},
    '{16'h12FF, 2'b11, 8'h12, 1'b0},
    '{16'hFF7F, 2'b10, 8'hFF, 1'b1},
    '{16'hFE80, 2'b01, 8'hFF, 1'b0},
    '{16'h0000, 2'b10, 8'h00, 1'b0}
  };

  logic [15:0] streamIn  [8] = '{16'h1000, 16'h1180, 16'h1300, 16'h1480,
                                 16'h1600, 16'h1780, 16'h1900, 16'h1A80};
  logic [7:0]  streamExp [8] = '{8'h10, 8'h12, 8'h13, 8'h15,
                                 8'h16, 8'h18, 8'h19, 8'h1B};

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Called one step after a rising edge; leaves the result consumed and the pipe empty.
  task automatic applyStimulus(input string tag, input logic [15:0] data,
                               input logic [1:0] mode, input logic [7:0] expData,
                               input logic expSat);
    in_valid = 1'b1;
    in_data  = data;
    in_mode  = mode;
    checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput({tag, "_not_early"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_data"}, 32'(out_data), 32'(expData));
    checkOutput({tag, "_sat"}, 32'(out_sat), 32'(expSat));
    @(posedge clk); #1;
  endtask

  initial begin
    int txIdx;
    int rxIdx;
    logic accepted;
    logic sawDrop;
    logic prevStall;
    logic [7:0] heldData;
    logic heldSat;
    logic [CNT_W-1:0] satBefore;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = 2'b00;
    out_ready = 1'b1;
    stat_clr  = 1'b0;

    #12;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    checkOutput("rst_out_sat", 32'(out_sat), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_rup_cnt", 32'(stat_rup_cnt), 32'd0);
    checkOutput("rst_sat_cnt", 32'(stat_sat_cnt), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].data, vecs[i].mode,
                    vecs[i].expData, vecs[i].expSat);
    end

    satBefore = stat_sat_cnt;
    applyStimulus("sat_rhu", 16'hFF80, 2'b01, 8'hFF, 1'b1);
`ifdef APPROX_ROUND_STATS_EN
    checkOutput("sat_cnt_inc", 32'(stat_sat_cnt), 32'(satBefore) + 32'd1);
`else
    checkOutput("sat_cnt_tied", 32'(stat_sat_cnt), 32'd0);
    checkOutput("rup_cnt_tied", 32'(stat_rup_cnt), 32'd0);
`endif

    // Back-to-back stream with a three-cycle downstream stall.
    txIdx     = 0;
    rxIdx     = 0;
    sawDrop   = 1'b0;
    prevStall = 1'b0;
    heldData  = '0;
    heldSat   = 1'b0;
    for (int cyc = 0; cyc < 60 && rxIdx < 8; cyc++) begin
      out_ready = !(cyc >= 3 && cyc <= 5);
      in_valid  = (txIdx < 8);
      in_data   = (txIdx < 8) ? streamIn[txIdx] : 16'h0000;
      in_mode   = MODE_RHU;
      #1;
      if (prevStall) begin
        checkOutput("stall_valid", 32'(out_valid), 32'd1);
        checkOutput("stall_data", 32'(out_data), 32'(heldData));
        checkOutput("stall_sat", 32'(out_sat), 32'(heldSat));
      end
      if (!in_ready) sawDrop = 1'b1;
      prevStall = out_valid && !out_ready;
      heldData  = out_data;
      heldSat   = out_sat;
      if (out_valid && out_ready) begin
        checkOutput($sformatf("stream_data%0d", rxIdx), 32'(out_data), 32'(streamExp[rxIdx]));
        checkOutput($sformatf("stream_sat%0d", rxIdx), 32'(out_sat), 32'd0);
        rxIdx++;
      end
      accepted = in_valid && in_ready;
      @(posedge clk); #1;
      if (accepted) txIdx++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checkOutput("stream_rx_count", 32'(rxIdx), 32'd8);
    checkOutput("stream_tx_count", 32'(txIdx), 32'd8);
    checkOutput("stream_in_ready_drop", 32'(sawDrop), 32'd1);
    checkOutput("stream_no_dup", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    // Fill both stages, then reset mid-flight.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = MODE_RHU;
    in_data   = 16'h3080;
    @(posedge clk); #1;
    in_data   = 16'h3180;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    checkOutput("full_out_valid", 32'(out_valid), 32'd1);
    checkOutput("full_in_ready", 32'(in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("midrst_out_data", 32'(out_data), 32'd0);
    @(posedge clk); #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("postrst_no_output1", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    checkOutput("postrst_no_output2", 32'(out_valid), 32'd0);
    checkOutput("postrst_rup_cnt", 32'(stat_rup_cnt), 32'd0);
    checkOutput("postrst_sat_cnt", 32'(stat_sat_cnt), 32'd0);

    applyStimulus("rup0", 16'h3080, 2'b01, 8'h31, 1'b0);
    applyStimulus("rup1", 16'h40FF, 2'b10, 8'h41, 1'b0);
    applyStimulus("rup2", 16'h5080, 2'b10, 8'h51, 1'b0);
`ifdef APPROX_ROUND_STATS_EN
    checkOutput("rup_cnt_three", 32'(stat_rup_cnt), 32'd3);
`else
    checkOutput("rup_cnt_tied_after", 32'(stat_rup_cnt), 32'd0);
`endif
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    checkOutput("clr_rup_cnt", 32'(stat_rup_cnt), 32'd0);
    checkOutput("clr_sat_cnt", 32'(stat_sat_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
